// File: rtl/mips_if_stage_if.sv
// ---------------------------------------------------------------------------
// mips_if_stage_if
// Bus bundle between the instruction-fetch stage and its surroundings
// (hazard unit, branch resolution, instruction ROM and decode stage).
//   slave  modport : the fetch stage itself
//   master modport : the environment driving the fetch stage
// Signals:
//   stall_i        hold PC and IF/ID
//   redirect_i     load redirect_pc_i into PC and flush IF/ID
//   redirect_pc_i  redirect target (byte address)
//   imem_addr_o    ROM byte address (current PC)
//   imem_data_i    ROM word at imem_addr_o
//   if_id_instr_o  IF/ID instruction
//   if_id_pc4_o    IF/ID PC+4
//   if_id_valid_o  IF/ID holds a real instruction
//   misalign_o     one-cycle pulse after a redirect to an unaligned target
//   fetch_count_o  number of valid instructions loaded into IF/ID
// ---------------------------------------------------------------------------
interface mips_if_stage_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
    output imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
           misalign_o, fetch_count_o
  );

  modport master (
    output stall_i, redirect_i, redirect_pc_i, imem_data_i,
    input  imem_addr_o, if_id_instr_o, if_id_pc4_o, if_id_valid_o,
           misalign_o, fetch_count_o
  );
endinterface

// File: rtl/mips_if_stage.sv
// ---------------------------------------------------------------------------
// mips_if_stage
// Instruction-fetch stage of the pipelined MIPS core. Owns the program
// counter, addresses the instruction ROM combinationally from the PC and
// loads the IF/ID pipeline register. Per-edge priority is redirect, then
// stall, then normal advance.
// Ports:
//   clk  pipeline clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  mips_if_stage_if.slave (stall/redirect in, ROM address/data,
//        IF/ID outputs, misalign pulse, fetch counter)
// ---------------------------------------------------------------------------
module mips_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_if_stage_if.slave        bus
);

  // Redirect targets are forced onto a word boundary; the low bits only
  // feed the misalign report.
  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] t);
    return (t[1:0] != 2'b00);
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;
  logic        misalign_p1;
  logic [31:0] fetch_count;
  logic [31:0] pc_next4;

  assign pc_next4 = pc_p0 + 32'd4;

  // IF: PC drives the ROM directly, no input reaches the address.
  assign bus.imem_addr_o = pc_p0;

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0       <= RESET_PC;
      instr_p1    <= NOP_INSTR;
      pc4_p1      <= 32'd0;
      vld_p1      <= 1'b0;
      misalign_p1 <= 1'b0;
      fetch_count <= 32'd0;
    end else if (bus.redirect_i) begin
      // Wrong-path word on imem_data_i is dropped; one bubble results.
      pc_p0       <= align_target(bus.redirect_pc_i);
      instr_p1    <= NOP_INSTR;
      pc4_p1      <= 32'd0;
      vld_p1      <= 1'b0;
      misalign_p1 <= is_misaligned(bus.redirect_pc_i);
    end else if (bus.stall_i) begin
      misalign_p1 <= 1'b0;
    end else begin
      pc_p0       <= pc_next4;
      instr_p1    <= bus.imem_data_i;
      pc4_p1      <= pc_next4;
      vld_p1      <= 1'b1;
      misalign_p1 <= 1'b0;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign bus.if_id_instr_o = instr_p1;
  assign bus.if_id_pc4_o   = pc4_p1;
  assign bus.if_id_valid_o = vld_p1;
  assign bus.misalign_o    = misalign_p1;
  assign bus.fetch_count_o = fetch_count;

endmodule

// File: tb/tb_mips_if_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_if_stage
// Self-checking bench for mips_if_stage. A behavioural ROM answers
// imem_addr_o with 32'h2000_0000 + word index. Each driven cycle pushes the
// expected post-edge state onto a scoreboard queue, which is popped and
// compared after the edge; directed checks cover the fixed scenario values.
// ---------------------------------------------------------------------------
module tb_mips_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic rst;
  mips_if_stage_if bus();

  mips_if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2000_0000 + {2'b00, a[31:2]};
  endfunction

  assign bus.imem_data_i = rom(bus.imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.instr = NOP; m.pc4 = 32'h0;
    m.vld = 1'b0; m.mis = 1'b0; m.cnt = 32'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"},  bus.imem_addr_o,   32'h0);
    chk({tag, "_vld"},   bus.if_id_valid_o, 32'h0);
    chk({tag, "_instr"}, bus.if_id_instr_o, NOP);
    chk({tag, "_pc4"},   bus.if_id_pc4_o,   32'h0);
    chk({tag, "_mis"},   bus.misalign_o,    32'h0);
    chk({tag, "_cnt"},   bus.fetch_count_o, 32'h0);
  endtask

  // Drive one cycle's controls, predict the post-edge state, compare after it.
  task automatic step(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    bus.stall_i       = s;
    bus.redirect_i    = r;
    bus.redirect_pc_i = t;
    if (r) begin
      m.pc = {t[31:2], 2'b00}; m.instr = NOP; m.pc4 = 32'h0;
      m.vld = 1'b0; m.mis = (t[1:0] != 2'b00);
    end else if (s) begin
      m.mis = 1'b0;
    end else begin
      m.instr = rom(m.pc); m.pc4 = m.pc + 32'd4; m.vld = 1'b1;
      m.pc = m.pc + 32'd4; m.cnt = m.cnt + 32'd1; m.mis = 1'b0;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_addr",  bus.imem_addr_o,   e.pc);
    chk("sb_instr", bus.if_id_instr_o, e.instr);
    chk("sb_pc4",   bus.if_id_pc4_o,   e.pc4);
    chk("sb_vld",   bus.if_id_valid_o, {31'h0, e.vld});
    chk("sb_mis",   bus.misalign_o,    {31'h0, e.mis});
    chk("sb_cnt",   bus.fetch_count_o, e.cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_state("rst_hold");
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] cnt0;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #1;

    // Reset then free run
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    chk("run4_instr", bus.if_id_instr_o, 32'h2000_0003);
    chk("run4_pc4",   bus.if_id_pc4_o,   32'd16);
    chk("run4_cnt",   bus.fetch_count_o, 32'd4);

    // Stall while IF/ID holds the instruction from address 8
    do_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    repeat (2) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_instr", bus.if_id_instr_o, 32'h2000_0002);
      chk("stall_pc4",   bus.if_id_pc4_o,   32'd12);
      chk("stall_addr",  bus.imem_addr_o,   32'd12);
      chk("stall_cnt",   bus.fetch_count_o, 32'd3);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("post_stall_instr", bus.if_id_instr_o, 32'h2000_0003);

    // Redirect from PC=0x10 to 0x40
    chk("pre_redir_addr", bus.imem_addr_o, 32'h10);
    cnt0 = bus.fetch_count_o;
    step(1'b0, 1'b1, 32'h40);
    chk("redir_vld",   bus.if_id_valid_o, 32'h0);
    chk("redir_instr", bus.if_id_instr_o, NOP);
    chk("redir_addr",  bus.imem_addr_o,   32'h40);
    step(1'b0, 1'b0, 32'h0);
    chk("tgt_instr", bus.if_id_instr_o, 32'h2000_0010);
    chk("tgt_pc4",   bus.if_id_pc4_o,   32'h44);
    chk("tgt_cnt",   bus.fetch_count_o, cnt0 + 32'd1);

    // Redirect and stall together
    step(1'b1, 1'b1, 32'h80);
    chk("rs_addr", bus.imem_addr_o,   32'h80);
    chk("rs_vld",  bus.if_id_valid_o, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Misaligned redirect target
    step(1'b0, 1'b1, 32'h0000_0106);
    chk("mis_addr",  bus.imem_addr_o, 32'h104);
    chk("mis_pulse", bus.misalign_o,  32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("mis_clear", bus.misalign_o,  32'h0);
    step(1'b0, 1'b1, 32'h0000_0203);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_clear_stall", bus.misalign_o, 32'h0);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_addr",  bus.imem_addr_o,   32'h0);
    chk("wrap_pc4",   bus.if_id_pc4_o,   32'h0);
    chk("wrap_instr", bus.if_id_instr_o, 32'h5FFF_FFFF);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    chk("rel_instr", bus.if_id_instr_o, 32'h2000_0000);
    chk("rel_pc4",   bus.if_id_pc4_o,   32'd4);
    repeat (5) step($urandom_range(0, 3) == 0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_if_stage.md
# mips_if_stage

Instruction-fetch stage of the pipelined MIPS core, sitting directly upstream of the decode stage inside the CPU top that the system bench drives with `clk` and `rst`. It owns the program counter, addresses the instruction ROM, and loads the IF/ID pipeline register. It honours stall and redirect/flush requests from the hazard and branch logic. It also reports misaligned redirect targets and keeps a retired-fetch counter for simulation checks.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word inserted as a bubble (`sll $0,$0,0`).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_i`  in  1  hold PC and IF/ID (load-use hazard from the hazard unit).
- `redirect_i`  in  1  branch taken or jump resolved in ID; load a new PC and flush IF/ID.
- `redirect_pc_i`  in  32  redirect target.
- `imem_addr_o`  out  32  instruction ROM byte address; equals the current PC (combinational).
- `imem_data_i`  in  32  instruction word; combinational ROM read of `imem_addr_o`.
- `if_id_instr_o`  out  32  IF/ID instruction.
- `if_id_pc4_o`  out  32  IF/ID PC+4 of that instruction.
- `if_id_valid_o`  out  1  IF/ID holds a real fetched instruction, not a bubble.
- `misalign_o`  out  1  registered one-cycle pulse: the last redirect target had nonzero bits [1:0].
- `fetch_count_o`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- **Registers:** `pc`, `if_id_instr`, `if_id_pc4`, `if_id_valid`, `misalign`, `fetch_count`.
- **Reset values** (asynchronous, immediate on `rst`=1):
  - `pc`=`RESET_PC`, so `imem_addr_o`=`RESET_PC`.
  - `if_id_instr_o`=`NOP_INSTR`, `if_id_pc4_o`=0, `if_id_valid_o`=0.
  - `misalign_o`=0, `fetch_count_o`=0.
- **Per-edge priority:** redirect, then stall, then normal advance.
- **Redirect** (`redirect_i`=1, regardless of `stall_i`):
  - `pc` <= {`redirect_pc_i`[31:2], 2'b00}.
  - IF/ID <= bubble: `NOP_INSTR`, pc4=0, valid=0.
  - `misalign` <= (`redirect_pc_i`[1:0] != 0).
  - `fetch_count` unchanged.
  - The word on `imem_data_i` this cycle (the wrong-path fetch) is discarded.
- **Stall** (`stall_i`=1, `redirect_i`=0):
  - `pc` and all IF/ID registers hold.
  - `misalign` <= 0; `fetch_count` unchanged.
- **Advance** (both low):
  - `pc` <= `pc`+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - IF/ID <= {`imem_data_i`, `pc`+4, 1}.
  - `fetch_count` <= `fetch_count`+1, wrapping at 2^32.
  - `misalign` <= 0.
- **PC alignment:** `pc`[1:0] is always 00.
- **Pipeline state:** no state machine beyond the registers above. The stage is always fetching; a bubble is only produced by a redirect.
- **Reset mid-operation:** all registers return to their reset values immediately. The first edge after `rst` deasserts performs a normal advance from `RESET_PC`, unless stall or redirect is asserted.

## Timing
- Fetch latency: the instruction at address A is addressed in cycle n and visible on `if_id_instr_o` in cycle n+1, with `if_id_pc4_o`=A+4.
- Redirect sampled at edge k:
  - `imem_addr_o`=target from edge k onward.
  - IF/ID shows the bubble for the cycle after edge k.
  - The target instruction appears in IF/ID after edge k+1.
  - Branch penalty: exactly one bubble.
- Stall sampled for N consecutive edges: IF/ID and `imem_addr_o` are frozen for N cycles. No instruction is lost or duplicated, and `fetch_count` does not advance.
- `misalign_o` is high for exactly the one cycle following the redirect edge.
- All outputs other than `imem_addr_o` are registered. `imem_addr_o` is a direct copy of `pc`, with no combinational path from any input.

## Test plan
- **Reset then free run:** ROM word[i]=32'h2000_0000+i. Hold `rst` for 3 cycles, then release.
  - During reset: `imem_addr_o`=0, `if_id_valid_o`=0.
  - After 4 advances: IF/ID instr=32'h2000_0003, pc4=16, `fetch_count_o`=4.
- **Stall:** assert `stall_i` for 2 edges while IF/ID holds the instruction from address 8.
  - Instr, pc4=12 and `imem_addr_o`=12 stay constant for both edges; count is unchanged.
  - The next advance loads word 3.
- **Redirect:** while PC=0x10, assert `redirect_i` with target 0x40.
  - Next cycle: IF/ID valid=0, instr=`NOP_INSTR`, `imem_addr_o`=0x40.
  - Following cycle: IF/ID holds word 16 with pc4=0x44; count grew by 1, not 2.
- **Redirect plus stall:** assert `redirect_i` (target 0x80) and `stall_i` on the same edge.
  - Redirect wins: `imem_addr_o`=0x80 and IF/ID is a bubble.
- **Misaligned target:** redirect to 0x0000_0106.
  - `imem_addr_o`=0x104; `misalign_o`=1 for exactly one cycle, then 0.
- **Wrap and async reset:** redirect to 0xFFFF_FFFC, then advance; `imem_addr_o`=0 and IF/ID pc4=0.
  - Assert `rst` mid-cycle: outputs return to their reset values before the next clock edge.
